dmem_scheduler: RTL and testbench
=================================

Name: dmem_scheduler

Overview:
- Top-level sequencer and data-memory owner for the downsampling system.
- Shares the single-port 19-bit-address data memory between three users in turn: image loader (byte stream in), processor (MEM read/write), and result dumper (byte stream out).
- Issues the processor start pulse, watches processor status, and drives the LOAD -> RUN -> DUMP -> DONE phases.

Parameters:
- ADDR_W, 19, data-memory address width
- DATA_W, 8, pixel/byte width
- IMG_SIZE, 65536, bytes loaded at address 0 (256x256 input)
- OUT_BASE, 65536, first address of downsampled result
- OUT_SIZE, 16384, bytes dumped starting at OUT_BASE
- RUN_TIMEOUT, 2**22, max RUN cycles before error

Ports:
- clk  in  1  system clock
- RST_N  in  1  asynchronous active-low reset
- sys_start  in  1  one-cycle request to begin a job
- ld_valid  in  1  loader byte valid
- ld_data  in  8  loader byte
- ld_ready  out  1  scheduler accepts loader byte this cycle
- proc_start  out  1  processor start pulse
- proc_status  in  1  processor finished (level)
- proc_MEM  in  2  processor memory op: 00 idle, 01 read, 10 write, 11 treated as idle
- proc_addr  in  19  processor memory address
- proc_wdata  in  8  processor write data
- proc_rdata  out  8  read data returned to processor
- tx_ready  in  1  dumper can take a byte
- tx_valid  out  1  dump byte valid
- tx_data  out  8  dump byte
- mem_addr  out  19  data-memory address
- mem_wdata  out  8  data-memory write data
- mem_we  out  1  data-memory write enable
- mem_rdata  in  8  data-memory read data, registered, valid 1 cycle after address
- phase  out  3  current state encoding
- done  out  1  job complete (level, held in DONE)
- error  out  1  RUN timeout (sticky until next sys_start)

Behaviour:
- Reset values: state IDLE; all counters 0; ld_ready, proc_start, tx_valid, mem_we, done, error = 0; mem_addr, mem_wdata, tx_data, proc_rdata = 0.
- States: IDLE(0), LOAD(1), START(2), RUN(3), DUMP_RD(4), DUMP_WAIT(5), DUMP_SEND(6), DONE(7); phase = state.
- IDLE/DONE:
  - sys_start -> LOAD; clears ld_cnt, dump_cnt, run_cnt, done, error.
  - sys_start in any other state is ignored.
- LOAD:
  - ld_ready = 1.
  - On ld_valid: mem_we = 1, mem_addr = ld_cnt, mem_wdata = ld_data (same cycle, combinational), ld_cnt++.
  - Accepting byte IMG_SIZE-1 -> START.
  - ld_valid outside LOAD is ignored (ld_ready = 0).
- START:
  - proc_start = 1 for exactly one cycle -> RUN.
  - proc_status is not sampled in START.
- RUN:
  - mem_addr = proc_addr.
  - mem_we = (proc_MEM == 10); mem_wdata = proc_wdata.
  - proc_rdata = mem_rdata.
  - run_cnt++.
  - proc_status high -> DUMP_RD (status takes priority over timeout in the same cycle).
  - run_cnt == RUN_TIMEOUT-1 -> error = 1, DONE.
  - proc_MEM is ignored in every state except RUN.
- DUMP_RD: mem_addr = OUT_BASE + dump_cnt, mem_we = 0 -> DUMP_WAIT.
- DUMP_WAIT: capture mem_rdata into tx_data -> DUMP_SEND.
- DUMP_SEND:
  - tx_valid = 1; tx_data held stable until tx_ready.
  - On tx_ready: dump_cnt++; if dump_cnt == OUT_SIZE-1 -> DONE, else -> DUMP_RD.
  - Throughput: max 1 byte per 3 cycles.
- DONE: done = 1.
- Address arithmetic is ADDR_W wide and truncating; OUT_BASE+OUT_SIZE must not exceed 2**ADDR_W (elaboration-time assertion).
- Counters sized to clog2 of their limits; there is no wrap within a job.
- RST_N low mid-operation: immediate return to reset values. Memory contents are not cleared. A partially loaded image is discarded logically.

Decomposition:
- Shared package dmem_sched_pkg: state encoding constants (3-bit), MEM op codes (MEM_IDLE = 00, MEM_RD = 01, MEM_WR = 10).
- One natural sub-module: dmem_mux, the combinational memory-port mux selected by state. The scheduler FSM and counters remain in the top.

Test Plan (IMG_SIZE = 4, OUT_BASE = 8, OUT_SIZE = 2, RUN_TIMEOUT = 20):
- Reset check: RST_N low while in RUN -> next edge phase = 0; all outputs 0; proc_start never pulses.
- Load: sys_start, stream bytes 11, 22, 33, 44 with one idle gap -> mem writes to addresses 0-3 with those values; phase 2 then 3; proc_start is a single-cycle pulse.
- RUN passthrough: proc_MEM = 10, addr 8, data AA, then proc_MEM = 01, addr 8 -> mem_we high one cycle; proc_rdata = AA one cycle later; proc_MEM = 11 -> mem_we = 0.
- Dump with backpressure: proc_status = 1, tx_ready held low 5 cycles -> tx_valid high with tx_data = AA stable; then bytes from addr 8 and 9 in order; done = 1, phase = 7.
- Timeout: processor never asserts status -> error = 1 and DONE after 20 RUN cycles; tx_valid never asserted.
- Ignored inputs: sys_start during LOAD, and ld_valid during RUN -> no state change, no mem_we from loader.

Source files
------------

// File: rtl/dmem_sched_pkg.sv
// Shared definitions for the downsampling-system memory scheduler:
// phase encoding, processor memory op codes and a counter-width helper.
package dmem_sched_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LOAD      = 3'd1,
    ST_START     = 3'd2,
    ST_RUN       = 3'd3,
    ST_DUMP_RD   = 3'd4,
    ST_DUMP_WAIT = 3'd5,
    ST_DUMP_SEND = 3'd6,
    ST_DONE      = 3'd7
  } state_t;

  typedef enum logic [1:0] {
    MEM_IDLE = 2'b00,
    MEM_RD   = 2'b01,
    MEM_WR   = 2'b10,
    MEM_RSVD = 2'b11
  } mem_op_t;

  // Width of a counter that must hold values 0 .. limit-1 (never narrower than 1 bit).
  function automatic int cnt_width(input int limit);
    return (limit > 1) ? $clog2(limit) : 1;
  endfunction

endpackage

// File: rtl/dmem_mux.sv
// Combinational data-memory port mux: hands the single memory port to the
// loader, the processor or the dumper depending on the scheduler phase.
module dmem_mux
  import dmem_sched_pkg::*;
#(
  parameter int ADDR_W = 19,
  parameter int DATA_W = 8
) (
  input  state_t              state,
  input  logic                ld_valid,
  input  logic [ADDR_W-1:0]   ld_addr,
  input  logic [DATA_W-1:0]   ld_data,
  input  logic [1:0]          proc_mem,
  input  logic [ADDR_W-1:0]   proc_addr,
  input  logic [DATA_W-1:0]   proc_wdata,
  input  logic [ADDR_W-1:0]   dump_addr,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic                mem_we,
  output logic [DATA_W-1:0]   proc_rdata
);

  always_comb begin
    // NOTE: every output gets a default before the case so no path can infer a latch.
    mem_addr   = '0;
    mem_wdata  = '0;
    mem_we     = 1'b0;
    proc_rdata = '0;
    case (state)
      ST_LOAD: begin
        if (ld_valid) begin
          mem_we    = 1'b1;
          mem_addr  = ld_addr;
          mem_wdata = ld_data;
        end
      end
      ST_RUN: begin
        mem_addr   = proc_addr;
        mem_wdata  = proc_wdata;
        mem_we     = (proc_mem == MEM_WR);
        proc_rdata = mem_rdata;
      end
      ST_DUMP_RD: mem_addr = dump_addr;
      default: ;
    endcase
  end

endmodule

// File: rtl/dmem_scheduler.sv
// Top-level sequencer for the downsampling system: owns the data memory and
// walks LOAD -> START -> RUN -> DUMP -> DONE for each job.
module dmem_scheduler
  import dmem_sched_pkg::*;
#(
  parameter int ADDR_W      = 19,
  parameter int DATA_W      = 8,
  parameter int IMG_SIZE    = 65536,
  parameter int OUT_BASE    = 65536,
  parameter int OUT_SIZE    = 16384,
  parameter int RUN_TIMEOUT = 2**22
) (
  input  logic                clk,
  input  logic                RST_N,
  input  logic                sys_start,
  input  logic                ld_valid,
  input  logic [DATA_W-1:0]   ld_data,
  output logic                ld_ready,
  output logic                proc_start,
  input  logic                proc_status,
  input  logic [1:0]          proc_MEM,
  input  logic [ADDR_W-1:0]   proc_addr,
  input  logic [DATA_W-1:0]   proc_wdata,
  output logic [DATA_W-1:0]   proc_rdata,
  input  logic                tx_ready,
  output logic                tx_valid,
  output logic [DATA_W-1:0]   tx_data,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic                mem_we,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic [2:0]          phase,
  output logic                done,
  output logic                error
);

  localparam int LD_W   = cnt_width(IMG_SIZE);
  localparam int DUMP_W = cnt_width(OUT_SIZE);
  localparam int RUN_W  = cnt_width(RUN_TIMEOUT);

  if ((longint'(OUT_BASE) + longint'(OUT_SIZE)) > (longint'(1) << ADDR_W)) begin : g_out_range_check
    $error("dmem_scheduler: OUT_BASE + OUT_SIZE exceeds the data-memory address space");
  end

  state_t            state;
  logic [LD_W-1:0]   ld_cnt;
  logic [DUMP_W-1:0] dump_cnt;
  logic [RUN_W-1:0]  run_cnt;
  logic [ADDR_W-1:0] dump_addr;

  assign dump_addr  = ADDR_W'(OUT_BASE) + ADDR_W'(dump_cnt);
  assign phase      = state;
  assign ld_ready   = (state == ST_LOAD);
  assign proc_start = (state == ST_START);
  assign tx_valid   = (state == ST_DUMP_SEND);
  assign done       = (state == ST_DONE);

  dmem_mux #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_mux (
    .state      (state),
    .ld_valid   (ld_valid),
    .ld_addr    (ADDR_W'(ld_cnt)),
    .ld_data    (ld_data),
    .proc_mem   (proc_MEM),
    .proc_addr  (proc_addr),
    .proc_wdata (proc_wdata),
    .dump_addr  (dump_addr),
    .mem_rdata  (mem_rdata),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_we     (mem_we),
    .proc_rdata (proc_rdata)
  );

  // NOTE: the data memory lives outside this block and is never cleared by
  // reset; clearing ld_cnt is what discards a partially loaded image.
  always_ff @(posedge clk or negedge RST_N) begin
    if (!RST_N) begin
      state    <= ST_IDLE;
      ld_cnt   <= '0;
      dump_cnt <= '0;
      run_cnt  <= '0;
      error    <= 1'b0;
      tx_data  <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every register update based on
      // the pre-edge values, independent of statement order.
      case (state)
        ST_IDLE, ST_DONE: begin
          if (sys_start) begin
            state    <= ST_LOAD;
            ld_cnt   <= '0;
            dump_cnt <= '0;
            run_cnt  <= '0;
            error    <= 1'b0;
          end
        end
        ST_LOAD: begin
          if (ld_valid) begin
            ld_cnt <= ld_cnt + 1'b1;
            if (ld_cnt == LD_W'(IMG_SIZE - 1)) state <= ST_START;
          end
        end
        ST_START: state <= ST_RUN;
        ST_RUN: begin
          run_cnt <= run_cnt + 1'b1;
          if (proc_status) begin
            state <= ST_DUMP_RD;
          end else if (run_cnt == RUN_W'(RUN_TIMEOUT - 1)) begin
            error <= 1'b1;
            state <= ST_DONE;
          end
        end
        ST_DUMP_RD:   state <= ST_DUMP_WAIT;
        ST_DUMP_WAIT: begin
          tx_data <= mem_rdata;
          state   <= ST_DUMP_SEND;
        end
        ST_DUMP_SEND: begin
          if (tx_ready) begin
            dump_cnt <= dump_cnt + 1'b1;
            state    <= (dump_cnt == DUMP_W'(OUT_SIZE - 1)) ? ST_DONE : ST_DUMP_RD;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_scheduler.sv
// Self-checking bench for dmem_scheduler with a small data-memory model and a
// byte-array reference of what the memory should hold after each phase.
module tb_dmem_scheduler;

  localparam int ADDR_W      = 19;
  localparam int DATA_W      = 8;
  localparam int IMG_SIZE    = 4;
  localparam int OUT_BASE    = 8;
  localparam int OUT_SIZE    = 2;
  localparam int RUN_TIMEOUT = 20;

  logic              clk;
  logic              RST_N;
  logic              sys_start;
  logic              ld_valid;
  logic [7:0]        ld_data;
  logic              ld_ready;
  logic              proc_start;
  logic              proc_status;
  logic [1:0]        proc_MEM;
  logic [ADDR_W-1:0] proc_addr;
  logic [7:0]        proc_wdata;
  logic [7:0]        proc_rdata;
  logic              tx_ready;
  logic              tx_valid;
  logic [7:0]        tx_data;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic              mem_we;
  logic [7:0]        mem_rdata;
  logic [2:0]        phase;
  logic              done;
  logic              error;

  int checks = 0;
  int errors = 0;

  dmem_scheduler #(
    .ADDR_W      (ADDR_W),
    .DATA_W      (DATA_W),
    .IMG_SIZE    (IMG_SIZE),
    .OUT_BASE    (OUT_BASE),
    .OUT_SIZE    (OUT_SIZE),
    .RUN_TIMEOUT (RUN_TIMEOUT)
  ) dut (
    .clk         (clk),
    .RST_N       (RST_N),
    .sys_start   (sys_start),
    .ld_valid    (ld_valid),
    .ld_data     (ld_data),
    .ld_ready    (ld_ready),
    .proc_start  (proc_start),
    .proc_status (proc_status),
    .proc_MEM    (proc_MEM),
    .proc_addr   (proc_addr),
    .proc_wdata  (proc_wdata),
    .proc_rdata  (proc_rdata),
    .tx_ready    (tx_ready),
    .tx_valid    (tx_valid),
    .tx_data     (tx_data),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_we      (mem_we),
    .mem_rdata   (mem_rdata),
    .phase       (phase),
    .done        (done),
    .error       (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read memory: data for an address appears one cycle later.
  logic [7:0] tb_mem [0:31];
  logic       mem_clear;
  always @(posedge clk) begin
    if (mem_clear) begin
      for (int i = 0; i < 32; i++) tb_mem[i] <= 8'h00;
    end else if (mem_we) begin
      tb_mem[mem_addr[4:0]] <= mem_wdata;
    end
    mem_rdata <= tb_mem[mem_addr[4:0]];
  end

  int start_pulses = 0;
  int tx_valid_cycles = 0;
  always @(posedge clk) begin
    if (proc_start) start_pulses <= start_pulses + 1;
    if (tx_valid)   tx_valid_cycles <= tx_valid_cycles + 1;
  end

  // Reference contents of the data memory as the specification's rules dictate.
  logic [7:0] model_mem [0:31];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    RST_N = 1'b0; sys_start = 0; ld_valid = 0; ld_data = 0; proc_status = 0;
    proc_MEM = 0; proc_addr = 0; proc_wdata = 0; tx_ready = 0; mem_clear = 1'b1;
    for (int i = 0; i < 32; i++) model_mem[i] = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    RST_N = 1'b1; mem_clear = 1'b0;
    tick();
    checks++;
    if ({phase, done, error, ld_ready, proc_start, tx_valid, mem_we} !== 9'd0) begin
      errors++; $display("FAIL reset_ctrl: got %b, expected 0", {phase, done, error, ld_ready, proc_start, tx_valid, mem_we});
    end
    checks++;
    if ({mem_addr, mem_wdata, tx_data, proc_rdata} !== '0) begin
      errors++; $display("FAIL reset_data: got %0h, expected 0", {mem_addr, mem_wdata, tx_data, proc_rdata});
    end
    tick(); tick();
    checks++;
    if (phase !== 3'd0 || start_pulses !== 0) begin
      errors++; $display("FAIL idle_hold: got phase %0d pulses %0d, expected phase 0 pulses 0", phase, start_pulses);
    end
  endtask

  // Streams IMG_SIZE random bytes with idle gaps and one ignored sys_start,
  // leaving the DUT in the first RUN cycle.
  task automatic load_image();
    int  k = 0;
    int  guard = 0;
    bit  gap_done = 0;
    bit  gap;
    sys_start = 1'b1;
    tick();
    sys_start = 1'b0;
    while (k < IMG_SIZE && guard < 60) begin
      guard++;
      gap = (k == 2 && !gap_done) || ($urandom_range(0, 3) == 0);
      if (gap) begin
        ld_valid  = 1'b0;
        sys_start = (k == 2 && !gap_done);
        #1;
        checks++;
        if (phase !== 3'd1 || mem_we !== 1'b0 || ld_ready !== 1'b1) begin
          errors++; $display("FAIL load_gap: got phase %0d we %b ready %b, expected 1 0 1", phase, mem_we, ld_ready);
        end
        if (sys_start) gap_done = 1;
        tick();
        sys_start = 1'b0;
      end else begin
        ld_valid = 1'b1;
        ld_data  = 8'($urandom);
        #1;
        checks++;
        if (mem_we !== 1'b1 || mem_addr !== ADDR_W'(k) || mem_wdata !== ld_data || ld_ready !== 1'b1) begin
          errors++; $display("FAIL load_write: got we %b addr %0h data %0h, expected 1 %0h %0h", mem_we, mem_addr, mem_wdata, k, ld_data);
        end
        model_mem[k] = ld_data;
        k++;
        tick();
      end
    end
    ld_valid = 1'b0;
    if (k < IMG_SIZE) begin
      errors++; $display("FAIL load_budget: got %0d bytes accepted, expected %0d", k, IMG_SIZE);
    end
    #1;
    checks++;
    if (phase !== 3'd2 || proc_start !== 1'b1) begin
      errors++; $display("FAIL start_pulse: got phase %0d start %b, expected 2 1", phase, proc_start);
    end
    tick();
    checks++;
    if (phase !== 3'd3 || proc_start !== 1'b0) begin
      errors++; $display("FAIL run_entry: got phase %0d start %b, expected 3 0", phase, proc_start);
    end
  endtask

  task automatic test_load();
    int pulses_before = start_pulses;
    load_image();
    checks++;
    if (start_pulses !== pulses_before + 1) begin
      errors++; $display("FAIL start_count: got %0d pulses, expected %0d", start_pulses - pulses_before, 1);
    end
  endtask

  // Processor traffic during RUN: fixed write/read/reserved ops, then random ones.
  task automatic test_run();
    logic [1:0] op;
    int         a;
    logic [7:0] d;
    bit         pend_rd = 0;
    logic [7:0] pend_val = 8'h00;
    for (int i = 0; i < 11; i++) begin
      case (i)
        0:  begin op = 2'b10; a = 8; end
        1:  begin op = 2'b10; a = 9; end
        2:  begin op = 2'b01; a = 8; end
        3:  begin op = 2'b11; a = 9; end
        10: begin op = 2'b01; a = 9; end
        default: begin op = 2'($urandom_range(0, 3)); a = $urandom_range(0, 15); end
      endcase
      d = 8'($urandom);
      proc_MEM = op; proc_addr = ADDR_W'(a); proc_wdata = d;
      ld_valid = (i == 3); ld_data = 8'h5A;
      #1;
      checks++;
      if (mem_we !== (op == 2'b10) || mem_addr !== ADDR_W'(a) || mem_wdata !== d) begin
        errors++; $display("FAIL run_port op%0d: got we %b addr %0h data %0h, expected %b %0h %0h", i, mem_we, mem_addr, mem_wdata, op == 2'b10, a, d);
      end
      if (i == 3) begin
        checks++;
        if (ld_ready !== 1'b0 || phase !== 3'd3) begin
          errors++; $display("FAIL run_ignore_ld: got ready %b phase %0d, expected 0 3", ld_ready, phase);
        end
      end
      if (pend_rd) begin
        checks++;
        if (proc_rdata !== pend_val) begin
          errors++; $display("FAIL run_rdata op%0d: got %0h, expected %0h", i, proc_rdata, pend_val);
        end
      end
      pend_rd  = (op == 2'b01);
      pend_val = model_mem[a];
      if (op == 2'b10) model_mem[a] = d;
      tick();
    end
    proc_MEM = 2'b00; ld_valid = 1'b0;
    #1;
    checks++;
    if (pend_rd && proc_rdata !== pend_val) begin
      errors++; $display("FAIL run_rdata_last: got %0h, expected %0h", proc_rdata, pend_val);
    end
    tick();
  endtask

  task automatic test_dump();
    logic [7:0] exp_b;
    int         hold;
    proc_MEM = 2'b00; proc_status = 1'b1;
    tick();
    proc_status = 1'b0;
    for (int k = 0; k < OUT_SIZE; k++) begin
      exp_b = model_mem[OUT_BASE + k];
      #1;
      checks++;
      if (phase !== 3'd4 || mem_addr !== ADDR_W'(OUT_BASE + k) || mem_we !== 1'b0 || tx_valid !== 1'b0) begin
        errors++; $display("FAIL dump_rd%0d: got phase %0d addr %0h we %b, expected 4 %0h 0", k, phase, mem_addr, mem_we, OUT_BASE + k);
      end
      tick();
      checks++;
      if (phase !== 3'd5 || tx_valid !== 1'b0) begin
        errors++; $display("FAIL dump_wait%0d: got phase %0d valid %b, expected 5 0", k, phase, tx_valid);
      end
      tick();
      hold = (k == 0) ? 5 : $urandom_range(0, 3);
      for (int j = 0; j <= hold; j++) begin
        tx_ready = (j == hold);
        #1;
        checks++;
        if (tx_valid !== 1'b1 || tx_data !== exp_b) begin
          errors++; $display("FAIL dump_send%0d: got valid %b data %0h, expected 1 %0h", k, tx_valid, tx_data, exp_b);
        end
        tick();
      end
      tx_ready = 1'b0;
    end
    #1;
    checks++;
    if (phase !== 3'd7 || done !== 1'b1 || error !== 1'b0 || tx_valid !== 1'b0) begin
      errors++; $display("FAIL dump_done: got phase %0d done %b error %b, expected 7 1 0", phase, done, error);
    end
  endtask

  task automatic test_timeout();
    int n = 0;
    int tx_before;
    load_image();
    tx_before = tx_valid_cycles;
    proc_MEM = 2'b00; proc_status = 1'b0;
    while (phase == 3'd3 && n < 2 * RUN_TIMEOUT) begin
      tick();
      n++;
    end
    checks++;
    if (n !== RUN_TIMEOUT || phase !== 3'd7) begin
      errors++; $display("FAIL timeout_len: got %0d cycles phase %0d, expected %0d 7", n, phase, RUN_TIMEOUT);
    end
    checks++;
    if (error !== 1'b1 || done !== 1'b1 || tx_valid_cycles !== tx_before) begin
      errors++; $display("FAIL timeout_flags: got error %b done %b tx %0d, expected 1 1 0", error, done, tx_valid_cycles - tx_before);
    end
    tick();
    checks++;
    if (error !== 1'b1 || phase !== 3'd7) begin
      errors++; $display("FAIL error_sticky: got error %b phase %0d, expected 1 7", error, phase);
    end
    sys_start = 1'b1;
    tick();
    sys_start = 1'b0;
    #1;
    checks++;
    if (phase !== 3'd1 || error !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL restart_clear: got phase %0d error %b done %b, expected 1 0 0", phase, error, done);
    end
  endtask

  task automatic test_reset_mid_run();
    int pulses;
    load_image();
    tick(); tick();
    pulses = start_pulses;
    #3;
    RST_N = 1'b0;
    #1;
    checks++;
    if ({phase, done, error, ld_ready, proc_start, tx_valid, mem_we} !== 9'd0 ||
        {mem_addr, mem_wdata, tx_data, proc_rdata} !== '0) begin
      errors++; $display("FAIL reset_async: got phase %0d we %b addr %0h, expected all 0", phase, mem_we, mem_addr);
    end
    ld_valid = 1'b1; ld_data = 8'hC3;
    tick();
    checks++;
    if (phase !== 3'd0) begin
      errors++; $display("FAIL reset_edge: got phase %0d, expected 0", phase);
    end
    @(negedge clk);
    RST_N = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (phase !== 3'd0 || mem_we !== 1'b0 || ld_ready !== 1'b0 || start_pulses !== pulses) begin
        errors++; $display("FAIL post_reset%0d: got phase %0d we %b pulses %0d, expected 0 0 %0d", i, phase, mem_we, start_pulses, pulses);
      end
    end
    ld_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_load();
    test_run();
    test_dump();
    test_timeout();
    test_reset_mid_run();
    test_load();
    test_run();
    test_dump();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
